// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file writeback path.
// Holds the register-file geometry and the requester identifiers used by the arbiter.
package regfile_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    logic [NREG-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority pointer advanced on accept.
// After reset requester 0 holds priority.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] request,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_e prio;

  always_comb begin
    grant = 2'b00;
    unique case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio == REQ_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The winner drops to lowest priority so the other side wins the next contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_ALU;
    end else if (accept) begin
      prio <= grant[0] ? REQ_LOAD : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port and
// tracks which registers still have an uncommitted write in flight.
module regfile_wb_arbiter #(
  parameter int XLEN = regfile_pkg::XLEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [regfile_pkg::REG_AW-1:0] req0_addr,
  input  logic [XLEN-1:0]              req0_data,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [regfile_pkg::REG_AW-1:0] req1_addr,
  input  logic [XLEN-1:0]              req1_data,
  input  logic                         iss_valid,
  input  logic [regfile_pkg::REG_AW-1:0] iss_rd,
  input  logic [regfile_pkg::REG_AW-1:0] rs1_addr,
  input  logic [regfile_pkg::REG_AW-1:0] rs2_addr,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic                         wr_en,
  output logic [regfile_pkg::REG_AW-1:0] wr_addr,
  output logic [XLEN-1:0]              wrdata,
  output logic [regfile_pkg::NREG-1:0] pend
);

  import regfile_pkg::*;

  logic [1:0]        request;
  logic [1:0]        grant;
  logic              accept;
  logic [REG_AW-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;

  logic              wr_en_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic [XLEN-1:0]   wrdata_q;

  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_set;
  logic [NREG-1:0]   pend_clr;

  // Masking requests during reset keeps both ready lines low for the whole reset.
  assign request = {req1_valid, req0_valid} & {2{~rst}};
  assign accept  = |grant;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .accept  (accept),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  // x0 writes are consumed here but never produce a write-enable pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wrdata_q  <= '0;
    end else begin
      wr_en_q <= accept && (sel_addr != REG_X0);
      if (accept) begin
        wr_addr_q <= sel_addr;
        wrdata_q  <= sel_data;
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    pend_set = '0;
    if (wr_en_q) begin
      pend_clr = reg_onehot(wr_addr_q);
    end
    if (iss_valid && (iss_rd != REG_X0)) begin
      pend_set = reg_onehot(iss_rd);
    end
  end

  // Set is applied after clear so a same-edge issue to the retiring register keeps it busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~pend_clr) | pend_set) & ~reg_onehot(REG_X0);
    end
  end

  assign wr_en    = wr_en_q & ~rst;
  assign wr_addr  = rst ? '0 : wr_addr_q;
  assign wrdata   = rst ? '0 : wrdata_q;
  assign pend     = rst ? '0 : pend_q;
  assign rs1_busy = pend[rs1_addr];
  assign rs2_busy = pend[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts grants and
// pending bits, and a queue of expected writes is matched against wr_en pulses.
module tb_regfile_wb_arbiter;

  localparam int XL = 64;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [4:0]    req0_addr = '0, req1_addr = '0;
  logic [XL-1:0] req0_data = '0, req1_data = '0;
  logic          iss_valid = 1'b0;
  logic [4:0]    iss_rd = '0;
  logic [4:0]    rs1_addr = '0, rs2_addr = '0;
  logic          rs1_busy, rs2_busy;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [XL-1:0] wrdata;
  logic [31:0]   pend;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  wr_t   sb[$];

  logic        m_prio = 1'b0;
  logic [31:0] m_pend = '0;
  logic        m_wr_v = 1'b0;
  logic [4:0]  m_wr_a = '0;
  logic        e_r0, e_r1;
  logic [31:0] e_pend;

  regfile_wb_arbiter #(.XLEN(XL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wrdata     (wrdata),
    .pend       (pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle either the head of the queue is due and must appear, or wr_en must be low.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL wb_missed: expected write addr %0d data %h at cycle %0d, wr_en stayed low", sb[0].addr, sb[0].data, sb[0].due);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== sb[0].addr || wrdata !== sb[0].data) begin
        errors++;
        $display("[TB] FAIL wb_write: got en %b addr %0d data %h, want en 1 addr %0d data %h", wr_en, wr_addr, wrdata, sb[0].addr, sb[0].data);
      end
      void'(sb.pop_front());
    end else begin
      checks++;
      if (wr_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wb_spurious: got wr_en %b addr %0d, want wr_en 0", wr_en, wr_addr);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of stimulus and wait to the negedge; expectations for this cycle are left in e_*.
  task automatic drive(input logic r,
                       input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                       input logic iv, input logic [4:0] ird);
    rst        = r;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    iss_valid  = iv; iss_rd = ird;
    if (r) begin
      sb.delete();
      e_r0   = 1'b0;
      e_r1   = 1'b0;
      e_pend = '0;
    end else begin
      if (v0 && v1) begin
        e_r0 = (m_prio == 1'b0);
        e_r1 = (m_prio == 1'b1);
      end else begin
        e_r0 = v0;
        e_r1 = v1;
      end
      e_pend = m_pend;
    end
    @(negedge clk);
  endtask

  // Advance the reference model across the rising edge and queue any expected write.
  task automatic advance();
    logic [31:0] nxt;
    if (rst) begin
      m_prio = 1'b0;
      m_pend = '0;
      m_wr_v = 1'b0;
    end else begin
      nxt = m_pend;
      if (m_wr_v) nxt[m_wr_a] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) nxt[iss_rd] = 1'b1;
      m_pend = nxt;
      m_wr_v = 1'b0;
      if (e_r0) begin
        m_prio = 1'b1;
        if (req0_addr != 5'd0) begin
          sb.push_back('{due: cyc + 1, addr: req0_addr, data: req0_data});
          m_wr_v = 1'b1;
          m_wr_a = req0_addr;
        end
      end else if (e_r1) begin
        m_prio = 1'b0;
        if (req1_addr != 5'd0) begin
          sb.push_back('{due: cyc + 1, addr: req1_addr, data: req1_data});
          m_wr_v = 1'b1;
          m_wr_a = req1_addr;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    advance();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66, 1'b1, 5'd3);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ready: got %b%b, want 00", req1_ready, req0_ready);
      end
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wrdata !== 64'd0 || pend !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got en %b addr %0d data %h pend %h, want all zero", wr_en, wr_addr, wrdata, pend);
      end
      advance();
    end
  endtask

  task automatic test_single();
    drive(1'b0, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b%b, want 01", req1_ready, req0_ready);
    end
    advance();
    idle();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wrdata !== 64'hAA) begin
      errors++;
      $display("[TB] FAIL single_write: got en %b addr %0d data %h, want 1 5 aa", wr_en, wr_addr, wrdata);
    end
    advance();
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'd1, 64'h100 + 64'(n0), 1'b1, 5'd2, 64'h200 + 64'(n1), 1'b0, 5'd0);
      checks++;
      if (req0_ready !== 1'((i % 2) == 0) || req1_ready !== 1'((i % 2) == 1)) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d: got %b%b, want %b%b", i, req1_ready, req0_ready, 1'((i % 2) == 1), 1'((i % 2) == 0));
      end
      if (i > 0) begin
        checks++;
        if (wr_en !== 1'b1) begin
          errors++;
          $display("[TB] FAIL contention_pulse%0d: got wr_en %b, want 1", i, wr_en);
        end
      end
      if (e_r0) n0++;
      else n1++;
      advance();
    end
    idle();
    advance();
  endtask

  task automatic test_x0();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3);
    advance();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0);
    checks++;
    if (req1_ready !== e_r1 || req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL x0_ready: got %b, want 1", req1_ready);
    end
    advance();
    idle();
    checks++;
    if (wr_en !== 1'b0 || pend !== 32'h0000_0008 || pend !== e_pend) begin
      errors++;
      $display("[TB] FAIL x0_nowrite: got en %b pend %h, want 0 00000008", wr_en, pend);
    end
    advance();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0);
    advance();
    idle();
    checks++;
    if (pend[0] !== 1'b0 || pend !== e_pend) begin
      errors++;
      $display("[TB] FAIL x0_pend: got %h, want %h", pend, e_pend);
    end
    advance();
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    advance();
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    idle();
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sb_busy: got rs1 %b rs2 %b, want 1 0", rs1_busy, rs2_busy);
    end
    advance();
    drive(1'b0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    advance();
    idle();
    checks++;
    if (wr_en !== 1'b1 || rs1_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sb_wrcycle: got en %b busy %b, want 1 1", wr_en, rs1_busy);
    end
    advance();
    idle();
    checks++;
    if (rs1_busy !== 1'b0 || pend !== e_pend) begin
      errors++;
      $display("[TB] FAIL sb_cleared: got busy %b pend %h, want 0 %h", rs1_busy, pend, e_pend);
    end
    advance();
  endtask

  task automatic test_same_edge();
    rs2_addr = 5'd9;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    advance();
    drive(1'b0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    advance();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    advance();
    idle();
    checks++;
    if (pend[9] !== 1'b1 || rs2_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_edge_set: got pend9 %b busy %b, want 1 1", pend[9], rs2_busy);
    end
    advance();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h999, 1'b0, 5'd0);
    advance();
    idle();
    advance();
    idle();
    checks++;
    if (pend[9] !== 1'b0 || pend !== e_pend) begin
      errors++;
      $display("[TB] FAIL same_edge_clear: got pend %h, want %h", pend, e_pend);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'(10 + i), 64'hB000 + 64'(i), 1'b0, 5'd0);
      checks++;
      if (req1_ready !== 1'b1 || (i > 0 && wr_en !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got ready %b wr_en %b, want 1 %b", i, req1_ready, wr_en, 1'(i > 0));
      end
      advance();
    end
    idle();
    advance();
  endtask

  task automatic test_reset_mid_write();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12);
    advance();
    drive(1'b0, 1'b1, 5'd12, 64'hC0DE, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    advance();
    drive(1'b1, 1'b1, 5'd13, 64'h1, 1'b1, 5'd14, 64'h2, 1'b0, 5'd0);
    checks++;
    if (wr_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || pend !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrst_during: got en %b ready %b%b pend %h, want 0 00 0", wr_en, req1_ready, req0_ready, pend);
    end
    advance();
    idle();
    checks++;
    if (wr_en !== 1'b0 || pend !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrst_after: got en %b pend %h, want 0 0", wr_en, pend);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_scoreboard();
    test_same_edge();
    test_back_to_back();
    test_reset_mid_write();
    for (int i = 0; i < 3; i++) begin
      idle();
      advance();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d outstanding writes, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Clocking and reset SHALL be one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-002 Parameter `XLEN`, default 64: width of write data.
REQ-003 Port `clk`, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port `rst`, input, 1: synchronous active-high reset.
REQ-005 Port `req0_valid`, input, 1: requester 0 (ALU writeback) has a write pending.
REQ-006 Port `req0_ready`, output, 1: requester 0 write accepted this cycle.
REQ-007 Port `req0_addr`, input, 5: requester 0 destination register.
REQ-008 Port `req0_data`, input, XLEN: requester 0 write data.
REQ-009 Ports `req1_valid`/`req1_ready`/`req1_addr`/`req1_data`: same directions and widths as requester 0, for requester 1 (load writeback).
REQ-010 Port `iss_valid`, input, 1: issue stage allocates a destination this cycle.
REQ-011 Port `iss_rd`, input, 5: allocated destination register.
REQ-012 Port `rs1_addr`/`rs2_addr`, input, 5 each: hazard query addresses.
REQ-013 Port `rs1_busy`/`rs2_busy`, output, 1 each: queried register has an uncommitted write.
REQ-014 Port `wr_en`, output, 1: register file write enable.
REQ-015 Port `wr_addr`, output, 5: register file write address.
REQ-016 Port `wrdata`, output, XLEN: register file write data.
REQ-017 Port `pend`, output, 32: scoreboard vector, bit i set means register i is busy.

Function
REQ-018 Arbitration SHALL be combinational and two-way round-robin; a sole valid requester is always granted.
REQ-019 With both requesters valid, the grant SHALL go to the requester not granted most recently; the pointer updates only on an accept.
REQ-020 Ready rule: `reqN_ready` = grant; a requester that is not granted SHALL hold valid/addr/data stable until ready.
REQ-021 Accept (valid & ready) SHALL register addr and data; `wr_en` = 1 with those values on the next cycle (latency 1, exactly one pulse).
REQ-022 An accept with addr 0 SHALL be consumed (ready = 1), but `wr_en` SHALL stay 0 on the next cycle.
REQ-023 Throughput: the block SHALL sustain one accept per cycle; back-to-back accepts produce back-to-back `wr_en` pulses.
REQ-024 Set rule: `iss_valid` with `iss_rd` != 0 SHALL set `pend[iss_rd]` at the edge.
REQ-025 Clear rule: at an edge where `wr_en` = 1, `pend[wr_addr]` SHALL clear, so the bit drops the cycle the register file holds the new value.
REQ-026 Simultaneous set and clear of the same index on one edge: set SHALL win.
REQ-027 `pend[0]` SHALL always read 0.
REQ-028 Issuing to a register already pending is illegal (the issue stage must stall on busy); if it occurs, the bit stays set and is cleared by the first write.
REQ-029 `rsN_busy` SHALL equal `pend[rsN_addr]` combinationally; address 0 gives 0.

Reset
REQ-030 While `rst` = 1: `req0_ready` = `req1_ready` = 0; `wr_en` = 0; `wr_addr` = 0; `wrdata` = 0; `pend` = 0; round-robin pointer set so requester 0 wins the first contention.
REQ-031 Reset mid-operation SHALL discard any registered write (no `wr_en` pulse the cycle after `rst`) and clear all pending bits.

Structure
REQ-032 Shared package `regfile_pkg` SHALL hold `XLEN` = 64, `REG_AW` = 5, `NREG` = 32, and `REG_X0` = 0.
REQ-033 Round-robin grant logic SHALL be the sub-module `rr_arb2` (request[1:0] in; grant[1:0] out; pointer updated on accept).

Verification
REQ-034 Scenario, single requester: req0 valid, addr 5, data 0xAA for one cycle -> ready0 = 1 that cycle; next cycle `wr_en` = 1, `wr_addr` = 5, `wrdata` = 0xAA.
REQ-035 Scenario, contention: both valid for 4 cycles, addr 1 and addr 2 -> grants 0,1,0,1 after reset; the losing request stays held; 4 consecutive `wr_en` pulses.
REQ-036 Scenario, x0 write: req1 valid, addr 0, data 0xFF -> ready1 = 1; `wr_en` stays 0; `pend` unchanged.
REQ-037 Scenario, scoreboard: issue rd 7, then rs1_addr = 7 -> `rs1_busy` = 1; accept write to 7 -> `wr_en` cycle still busy, next cycle busy = 0.
REQ-038 Scenario, same-edge set/clear: `wr_en` to 9 coincides with `iss_rd` = 9 -> `pend[9]` = 1 afterward.
REQ-039 Scenario, reset mid-write: `rst` asserted the cycle after an accept -> no `wr_en` pulse; `pend` = 0; both ready = 0 during reset.
